branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch/jump control for a small sequencer: IDLE/RUN/HALTED FSM, 32x9 jump-target
// table, jump-slot violation flag and a saturating run-cycle counter.
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic             op_branch,
  input  logic             op_jump,
  input  logic             op_halt,
  input  logic             cond,
  input  logic [4:0]       lut_idx,
  input  logic             read_jump,
  input  logic             lut_we,
  input  logic [4:0]       lut_waddr,
  input  logic [8:0]       lut_wdata,
  output logic             jump_en,
  output logic             branch_taken,
  output logic             branch_skip,
  output logic             halt,
  output logic [8:0]       jump_addr,
  output logic             done,
  output logic             slot_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [8:0]       r_table [32];
  logic             r_slot_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run;
  logic             w_launch;

  assign w_run    = (r_state == S_RUN);
  assign w_launch = !w_run && start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)   w_next = S_RUN;
      S_RUN:    if (op_halt) w_next = S_HALTED;
      S_HALTED: if (start)   w_next = S_RUN;
      default:               w_next = S_IDLE;
    endcase
  end

  // Outside RUN the PC is held: halt asserted, no redirects.
  always_comb begin
    halt         = 1'b1;
    jump_en      = 1'b0;
    branch_taken = 1'b0;
    branch_skip  = 1'b0;
    if (w_run) begin
      halt         = op_halt;
      branch_taken = op_branch & cond & ~op_halt;
      branch_skip  = op_branch & ~cond & ~op_halt;
      jump_en      = op_jump & ~op_branch & ~op_halt;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_state    <= S_IDLE;
      r_slot_err <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < 32; i++) r_table[i] <= 9'h000;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_slot_err <= 1'b0;
        r_cnt      <= '0;
      end else if (w_run) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        // A taken branch must be followed by the jump in its delay slot.
        if (read_jump && !op_jump) r_slot_err <= 1'b1;
      end
      if (lut_we && !w_run) r_table[lut_waddr] <= lut_wdata;
    end
  end

  assign jump_addr = r_table[lut_idx];
  assign done      = (r_state == S_HALTED);
  assign slot_err  = r_slot_err;
  assign cycle_cnt = r_cnt;

endmodule
